// File: rtl/clock_gen_p.sv
// Types shared by the transmit clock generator and the receive-side clock recovery.
package clock_gen_p;

  localparam int DEF_RATE_WIDTH  = 16;
  localparam int DEF_DELAY_WIDTH = 4;

  typedef logic [DEF_RATE_WIDTH-1:0]  half_rate_t;
  typedef logic [DEF_DELAY_WIDTH-1:0] tx_delay_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } gen_state_e;

  typedef struct packed {
    half_rate_t high;
    half_rate_t low;
    tx_delay_t  delay;
  } rate_cfg_s;

endpackage

// File: rtl/common_p.sv
// Shared clock-domain bundle used across the link datapath blocks.
package common_p;

  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom_s;

endpackage

// File: rtl/half_period_counter.sv
// Down-counter for one half period; flags the terminal count and the preempt point.
module half_period_counter #(
  parameter int RATE_WIDTH  = 16,
  parameter int DELAY_WIDTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   reload_i,
  input  logic [RATE_WIDTH-1:0]  load_val_i,
  input  logic                   dec_i,
  input  logic [DELAY_WIDTH-1:0] delay_i,
  output logic                   at_zero_o,
  output logic                   at_delay_o
);

  logic [RATE_WIDTH-1:0] cnt_q, cnt_d;

  // Saturates at zero rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (reload_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - RATE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_zero_o  = (cnt_q == '0);
  assign at_delay_o = (cnt_q == RATE_WIDTH'(delay_i));

endmodule

// File: rtl/preemptive_clock_gen.sv
// Transmit clock generator with programmable half periods and edge strobes
// issued a programmable number of cycles ahead of each generated edge.
module preemptive_clock_gen
  import clock_gen_p::*;
#(
  parameter int   RATE_WIDTH  = DEF_RATE_WIDTH,
  parameter int   DELAY_WIDTH = DEF_DELAY_WIDTH,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  common_p::clk_dom_s     sys_dom_i,
  input  logic                   enable_i,
  input  logic [RATE_WIDTH-1:0]  high_half_rate_i,
  input  logic [RATE_WIDTH-1:0]  low_half_rate_i,
  input  logic [DELAY_WIDTH-1:0] tx_delay_i,
  input  logic                   config_update_i,
  output logic                   clk_o,
  output logic                   rise_o,
  output logic                   fall_o,
  output logic                   preempt_rise_o,
  output logic                   preempt_fall_o,
  output logic                   busy_o,
  output logic                   config_err_o
);

  function automatic logic [RATE_WIDTH-1:0] clamp_rate(input logic [RATE_WIDTH-1:0] r);
    return (r == '0) ? RATE_WIDTH'(1) : r;
  endfunction

  logic clk, rst_n;
  assign clk   = sys_dom_i.clk;
  assign rst_n = sys_dom_i.rst_n;

  gen_state_e state_q, state_d;
  logic clk_q, clk_d;
  logic rise_q, rise_d, fall_q, fall_d;
  logic prise_q, prise_d, pfall_q, pfall_d;
  logic pend_q, pend_d;
  logic err_q, err_d;
  logic init_q;

  logic [RATE_WIDTH-1:0]  sh_high_q, sh_low_q;
  logic [DELAY_WIDTH-1:0] sh_dly_q;
  logic [RATE_WIDTH-1:0]  act_rate_q, act_rate_d;
  logic [DELAY_WIDTH-1:0] act_dly_q, act_dly_d;

  logic                   cfg_sel;
  logic [RATE_WIDTH-1:0]  cfg_high, cfg_low, start_rate, next_rate;
  logic [DELAY_WIDTH-1:0] cfg_dly;
  logic                   reload, dec, act_upd, stopping, preempt_ok;
  logic [RATE_WIDTH-1:0]  load_val;
  logic                   at_zero, at_delay;

  // An update coinciding with a reload is bypassed straight into that reload.
  assign cfg_sel    = config_update_i || !init_q;
  assign cfg_high   = cfg_sel ? high_half_rate_i : sh_high_q;
  assign cfg_low    = cfg_sel ? low_half_rate_i  : sh_low_q;
  assign cfg_dly    = cfg_sel ? tx_delay_i       : sh_dly_q;
  assign start_rate = clamp_rate(IDLE_LEVEL ? cfg_high : cfg_low);
  assign next_rate  = clamp_rate(clk_q ? cfg_low : cfg_high);

  assign stopping   = (state_q == STOP) || ((state_q == RUN) && !enable_i);
  assign preempt_ok = at_delay && !pend_q && (RATE_WIDTH'(act_dly_q) < act_rate_q);

  half_period_counter #(
    .RATE_WIDTH (RATE_WIDTH),
    .DELAY_WIDTH(DELAY_WIDTH)
  ) u_cnt (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .reload_i  (reload),
    .load_val_i(load_val),
    .dec_i     (dec),
    .delay_i   (act_dly_q),
    .at_zero_o (at_zero),
    .at_delay_o(at_delay)
  );

  always_comb begin
    state_d    = state_q;
    clk_d      = clk_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    prise_d    = 1'b0;
    pfall_d    = 1'b0;
    pend_d     = pend_q;
    err_d      = err_q;
    reload     = 1'b0;
    dec        = 1'b0;
    load_val   = '0;
    act_upd    = 1'b0;
    act_rate_d = act_rate_q;
    act_dly_d  = act_dly_q;

    case (state_q)
      IDLE: begin
        clk_d  = IDLE_LEVEL;
        pend_d = 1'b0;
        if (enable_i) begin
          state_d    = RUN;
          reload     = 1'b1;
          load_val   = RATE_WIDTH'(cfg_dly);
          act_upd    = 1'b1;
          act_rate_d = start_rate;
          act_dly_d  = cfg_dly;
        end
      end
      default: begin
        // At idle level with no preempt out yet, nothing is owed downstream.
        if (stopping && (clk_q == IDLE_LEVEL) && !pend_q) begin
          state_d = IDLE;
        end else begin
          state_d = stopping ? STOP : RUN;
          dec     = 1'b1;
          if (preempt_ok) begin
            pfall_d = clk_q;
            prise_d = !clk_q;
            pend_d  = 1'b1;
          end
          if (at_zero) begin
            clk_d      = !clk_q;
            rise_d     = !clk_q;
            fall_d     = clk_q;
            pend_d     = 1'b0;
            reload     = 1'b1;
            load_val   = next_rate - RATE_WIDTH'(1);
            act_upd    = 1'b1;
            act_rate_d = next_rate;
            act_dly_d  = cfg_dly;
          end
        end
      end
    endcase

    if (act_upd && (RATE_WIDTH'(act_dly_d) >= act_rate_d)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      clk_q   <= IDLE_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      prise_q <= 1'b0;
      pfall_q <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      prise_q <= prise_d;
      pfall_q <= pfall_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      init_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_sel) begin
      sh_high_q <= high_half_rate_i;
      sh_low_q  <= low_half_rate_i;
      sh_dly_q  <= tx_delay_i;
    end
    act_rate_q <= act_rate_d;
    act_dly_q  <= act_dly_d;
  end

  assign clk_o          = clk_q;
  assign rise_o         = rise_q;
  assign fall_o         = fall_q;
  assign preempt_rise_o = prise_q;
  assign preempt_fall_o = pfall_q;
  assign busy_o         = (state_q != IDLE);
  assign config_err_o   = err_q;

endmodule
